// File: rtl/dmem_copy_engine.sv
// Block-copy engine in front of the data memory. When idle it passes CPU
// traffic through; when started it owns the port and copies Len bytes forward.
module dmem_copy_engine #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  input  logic         CpuWriteEn,
  input  logic [A-1:0] CpuAddress,
  input  logic [W-1:0] CpuDataIn,
  input  logic [W-1:0] MemDataOut,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddress,
  output logic [W-1:0] MemDataIn,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  logic [A-1:0] r_src;
  logic [A-1:0] r_dst;
  logic [A-1:0] r_len;
  logic [A-1:0] r_idx;
  logic [W-1:0] r_buf;
  logic         w_last;

  assign w_last = (r_idx == r_len - 1'b1);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_src   <= SrcAddr;
            r_dst   <= DstAddr;
            r_len   <= Len;
            r_idx   <= '0;
            r_state <= (Len == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          r_buf   <= MemDataOut;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_READ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state == S_READ) || (r_state == S_WRITE);
  assign Done = (r_state == S_DONE);

  // Port mux: only registered state and Cpu* feed the outputs, never MemDataOut.
  always_comb begin
    MemWriteEn = CpuWriteEn;
    MemAddress = CpuAddress;
    MemDataIn  = CpuDataIn;
    case (r_state)
      S_READ: begin
        MemWriteEn = 1'b0;
        MemAddress = r_src + r_idx;
        MemDataIn  = '0;
      end
      S_WRITE: begin
        MemWriteEn = 1'b1;
        MemAddress = r_dst + r_idx;
        MemDataIn  = r_buf;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Directed bench for dmem_copy_engine with a behavioural 256x8 memory behind it.
module tb_dmem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] SrcAddr, DstAddr, Len;
  logic       CpuWriteEn;
  logic [7:0] CpuAddress, CpuDataIn;
  logic [7:0] MemDataOut;
  logic       MemWriteEn;
  logic [7:0] MemAddress, MemDataIn;
  logic       Busy, Done;

  logic [7:0] mem [0:255];
  int         wr_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 Clk = ~Clk;

  dmem_copy_engine #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
    .CpuWriteEn(CpuWriteEn), .CpuAddress(CpuAddress), .CpuDataIn(CpuDataIn),
    .MemDataOut(MemDataOut), .MemWriteEn(MemWriteEn), .MemAddress(MemAddress),
    .MemDataIn(MemDataIn), .Busy(Busy), .Done(Done)
  );

  assign MemDataOut = mem[MemAddress];

  always @(posedge Clk) begin
    if (MemWriteEn) begin
      mem[MemAddress] <= MemDataIn;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    CpuWriteEn = 1'b1; CpuAddress = a; CpuDataIn = d;
    tick();
    CpuWriteEn = 1'b0;
  endtask

  // Start a copy and watch a bounded window, collecting Busy/Done statistics.
  task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit restart, input bit cpu_st,
                          output int busy_n, output int done_n, output int done_at,
                          output int wr_n, output logic [7:0] m144,
                          output logic pt_we, output logic [7:0] pt_addr);
    int wr0;
    int budget;
    busy_n = 0; done_n = 0; done_at = -1; m144 = 8'h00; pt_we = 1'b0; pt_addr = 8'h00;
    budget = 2 * int'(l) + 6;
    wr0 = wr_cnt;
    SrcAddr = s; DstAddr = d; Len = l; Start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      tick();
      Start = 1'b0;
      if (c == 1 && cpu_st) begin
        CpuWriteEn = 1'b1; CpuAddress = 8'h90; CpuDataIn = 8'hEE;
      end
      #1;
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at < 0) begin
          done_at = c;
          m144 = mem[8'h90];
          pt_we = MemWriteEn;
          pt_addr = MemAddress;
          CpuWriteEn = 1'b0;
        end
      end
      if (restart && c == 3) begin
        SrcAddr = 8'h33; DstAddr = 8'h34; Len = 8'd1; Start = 1'b1;
      end
    end
    wr_n = wr_cnt - wr0;
  endtask

  int         bn, dn, da, wn;
  logic [7:0] m144, pa;
  logic       pw;

  initial begin
    Reset = 1'b1; Start = 1'b0; SrcAddr = 0; DstAddr = 0; Len = 0;
    CpuWriteEn = 1'b0; CpuAddress = 8'h5C; CpuDataIn = 8'h3D;
    #12;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_pt_addr", MemAddress, 8'h5C);
    chk("rst_pt_data", MemDataIn, 8'h3D);
    @(negedge Clk);
    Reset = 1'b0;
    tick();

    // passthrough store
    cpu_wr(8'h10, 8'hA5);
    chk("pt_mem16", mem[16], 8'hA5);
    chk("pt_busy", Busy, 0);
    chk("pt_done", Done, 0);

    // basic copy
    cpu_wr(8'h00, 8'h11); cpu_wr(8'h01, 8'h22); cpu_wr(8'h02, 8'h33); cpu_wr(8'h03, 8'h44);
    run_copy(8'h00, 8'h40, 8'd4, 1'b0, 1'b0, bn, dn, da, wn, m144, pw, pa);
    chk("basic_busy_cycles", bn, 8);
    chk("basic_done_cnt", dn, 1);
    chk("basic_done_at", da, 9);
    chk("basic_writes", wn, 4);
    chk("basic_m64", mem[64], 8'h11);
    chk("basic_m65", mem[65], 8'h22);
    chk("basic_m66", mem[66], 8'h33);
    chk("basic_m67", mem[67], 8'h44);
    chk("basic_src0", mem[0], 8'h11);
    chk("basic_src3", mem[3], 8'h44);

    // Len = 0
    run_copy(8'h00, 8'h50, 8'd0, 1'b0, 1'b0, bn, dn, da, wn, m144, pw, pa);
    chk("len0_busy", bn, 0);
    chk("len0_done_at", da, 1);
    chk("len0_done_cnt", dn, 1);
    chk("len0_writes", wn, 0);

    // Start while busy is ignored
    cpu_wr(8'h34, 8'h99);
    run_copy(8'h00, 8'h48, 8'd3, 1'b1, 1'b0, bn, dn, da, wn, m144, pw, pa);
    chk("restart_done_cnt", dn, 1);
    chk("restart_done_at", da, 7);
    chk("restart_writes", wn, 3);
    chk("restart_m4a", mem[8'h4A], 8'h33);
    chk("restart_m34", mem[8'h34], 8'h99);

    // address wrap
    cpu_wr(8'hFE, 8'h5A); cpu_wr(8'hFF, 8'h6B); cpu_wr(8'h00, 8'h7C);
    run_copy(8'hFE, 8'h20, 8'd3, 1'b0, 1'b0, bn, dn, da, wn, m144, pw, pa);
    chk("wrap_m20", mem[8'h20], 8'h5A);
    chk("wrap_m21", mem[8'h21], 8'h6B);
    chk("wrap_m22", mem[8'h22], 8'h7C);

    // overlapping forward copy replicates mem[0]
    cpu_wr(8'h00, 8'h7E);
    for (int i = 1; i <= 6; i++) cpu_wr(8'(i), 8'(8'hC0 + i));
    run_copy(8'h00, 8'h01, 8'd5, 1'b0, 1'b0, bn, dn, da, wn, m144, pw, pa);
    for (int i = 1; i <= 5; i++) chk($sformatf("ovl_m%0d", i), mem[i], 8'h7E);
    chk("ovl_m6", mem[6], 8'hC6);

    // reset mid-copy
    for (int i = 0; i < 6; i++) cpu_wr(8'(i), 8'(8'h A0 + i));
    for (int i = 0; i < 6; i++) cpu_wr(8'(8'h80 + i), 8'h00);
    SrcAddr = 8'h00; DstAddr = 8'h80; Len = 8'd6; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_busy_before", Busy, 1);
    Reset = 1'b1;
    #1;
    chk("mid_busy_after", Busy, 0);
    chk("mid_done_after", Done, 0);
    tick();
    chk("mid_done_hold", Done, 0);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    chk("mid_m128", mem[128], 8'hA0);
    chk("mid_m129", mem[129], 8'hA1);
    chk("mid_m130", mem[130], 8'h00);
    chk("mid_m133", mem[133], 8'h00);
    run_copy(8'h00, 8'h80, 8'd6, 1'b0, 1'b0, bn, dn, da, wn, m144, pw, pa);
    chk("post_done_at", da, 13);
    chk("post_m130", mem[130], 8'hA2);
    chk("post_m133", mem[133], 8'hA5);

    // CPU store during busy is dropped; passthrough returns in DONE
    cpu_wr(8'h90, 8'h12);
    run_copy(8'h00, 8'hB0, 8'd2, 1'b0, 1'b1, bn, dn, da, wn, m144, pw, pa);
    chk("cpu_m144", m144, 8'h12);
    chk("cpu_done_we", pw, 1);
    chk("cpu_done_addr", pa, 8'h90);
    chk("cpu_mb1", mem[8'hB1], 8'hA1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
- Block-copy engine placed directly upstream of the data memory, between the CPU datapath and the memory's single address/data/write port.
- When idle, it passes CPU load/store traffic straight through to the memory.
- When started, it takes over the port and copies Len bytes from SrcAddr to DstAddr, one read cycle plus one write cycle per byte. Software uses it for array moves and buffer initialisation without a load/store loop.

Parameters:
W, 8, data width in bits; matches the data memory word.
A, 8, address width in bits; memory depth 2**A; also the width of Len.

Ports:
Clk  input  1  system clock, all state updates on posedge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  request a copy; sampled on posedge only while idle.
SrcAddr  input  A  first source address; captured with Start.
DstAddr  input  A  first destination address; captured with Start.
Len  input  A  byte count; captured with Start; 0 = no transfer.
CpuWriteEn  input  1  CPU store enable (passthrough when idle).
CpuAddress  input  A  CPU load/store address (passthrough when idle).
CpuDataIn  input  W  CPU store data (passthrough when idle).
MemDataOut  input  W  combinational read data from the data memory.
MemWriteEn  output  1  write enable to the data memory.
MemAddress  output  A  address to the data memory.
MemDataIn  output  W  write data to the data memory.
Busy  output  1  engine owns the memory port; the CPU must stall.
Done  output  1  one-cycle pulse when a copy completes.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high. Reset forces state IDLE and clears all internal registers (src, dst, len, idx, buf).
- Reset values: Busy=0, Done=0. Mem* outputs are in passthrough, so MemAddress=CpuAddress, MemDataIn=CpuDataIn, MemWriteEn=CpuWriteEn.
- States: IDLE, READ, WRITE, DONE. Busy=1 in READ and WRITE; Done=1 only in DONE. Both are decoded from the state register.
- IDLE
  - Mem* = Cpu* passthrough.
  - On posedge with Start=1: capture SrcAddr, DstAddr and Len; set idx=0.
  - If Len==0, go to DONE; otherwise go to READ.
- READ
  - MemAddress = src+idx; MemWriteEn=0; MemDataIn=0.
  - On posedge: buf <= MemDataOut; go to WRITE.
- WRITE
  - MemAddress = dst+idx; MemDataIn = buf; MemWriteEn=1.
  - On posedge: if idx==len-1, go to DONE; else idx <= idx+1 and go to READ.
- DONE
  - Mem* = Cpu* passthrough; Done=1.
  - Next posedge: go to IDLE. Start in DONE is ignored.
- Latency
  - Start sampled at edge E0; Done is high in the cycle following edge E0+2*Len.
  - Len=0: Done is high in the cycle after E0.
  - Minimum Start-to-Start spacing: 2*Len+2 cycles.
- Address arithmetic: src+idx and dst+idx are A-bit and wrap modulo 2**A. idx is A bits; Len = 2**A-1 is the maximum.
- Overlap: strict forward byte-by-byte copy, no hazard detection.
  - DstAddr > SrcAddr with overlap replicates source bytes; this is the intended pattern-fill behaviour.
  - DstAddr < SrcAddr copies correctly.
  - DstAddr == SrcAddr rewrites identical data.
- CPU during Busy: CpuWriteEn, CpuAddress and CpuDataIn are ignored. A CPU store presented while Busy=1 is dropped. The CPU must hold on Busy.
- Start while busy (READ, WRITE or DONE): ignored; no re-capture.
- Reset mid-copy
  - Returns to IDLE immediately; Busy and Done go to 0 asynchronously; no Done pulse.
  - Bytes already written stay written; the remaining bytes are not written.
- Registered state only; Mem* outputs are a combinational mux of state, counters and Cpu* inputs. No combinational path from MemDataOut to any output.

Test Plan:
- Passthrough in IDLE: CpuWriteEn=1, CpuAddress=8'h10, CpuDataIn=8'hA5 for one edge -> mem[16]=8'hA5; Busy=0, Done=0 throughout.
- Basic copy: mem[0..3]={11,22,33,44}, Start with Src=0, Dst=8'h40, Len=4 -> Busy high for 8 cycles, Done pulses once at cycle 9, mem[64..67]={11,22,33,44}, mem[0..3] unchanged.
- Len=0 and Start while busy
  - Start with Len=0 -> Done in the next cycle, Busy never high, no memory write.
  - Second Start asserted mid-copy -> ignored; exactly one Done.
- Wrap and overlap
  - Src=8'hFE, Dst=8'h20, Len=3 -> reads 254, 255, 0.
  - mem[0]=8'h7E, Src=0, Dst=1, Len=5 -> mem[1..5] all 8'h7E.
- Reset mid-copy: Src=0, Dst=8'h80, Len=6, assert Reset asynchronously after 5 cycles -> Busy and Done drop immediately; mem[128..129] written, mem[130..133] untouched; next Start works normally.
- CPU store while busy: CpuWriteEn=1, CpuAddress=8'h90 during copy -> mem[144] unchanged; Mem* resume passthrough in the DONE cycle.
